vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 37 +++
 rtl/vga_timing_gen_sync_delay.sv | 44 ++++
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 tb/tb_vga_timing_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared raster constants, coordinate type and total helpers
// for the 640x480 @ 60 Hz display path. Renderers import this as well.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  // Default 640x480 @ 60 Hz timing (25 MHz pixel clock)
  localparam int unsigned H_VISIBLE_640 = 640;
  localparam int unsigned H_FRONT_640   = 16;
  localparam int unsigned H_SYNC_640    = 96;
  localparam int unsigned H_BACK_640    = 48;
  localparam int unsigned V_VISIBLE_640 = 480;
  localparam int unsigned V_FRONT_640   = 10;
  localparam int unsigned V_SYNC_640    = 2;
  localparam int unsigned V_BACK_640    = 33;

  // Largest period a coord_t counter can cover
  localparam int unsigned MAX_TOTAL      = 1 << COORD_W;
  localparam int unsigned MAX_SYNC_DELAY = 4;

  // Full period of one axis (visible + porches + sync)
  function automatic int unsigned span_total(
    input int unsigned visible,
    input int unsigned front,
    input int unsigned sync,
    input int unsigned back
  );
    return visible + front + sync + back;
  endfunction

  localparam int unsigned H_TOTAL_640 =
    span_total(H_VISIBLE_640, H_FRONT_640, H_SYNC_640, H_BACK_640);
  localparam int unsigned V_TOTAL_640 =
    span_total(V_VISIBLE_640, V_FRONT_640, V_SYNC_640, V_BACK_640);

endpackage

// File: rtl/vga_timing_gen_sync_delay.sv
// sync_delay: DEPTH-stage shift register whose stages clear to all-ones on
// reset, so an active-low sync can never leave reset asserted. DEPTH=0 is a
// straight wire.
module sync_delay #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 2
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = vga_clk ^ reset_n;
      assign dout = din;
    end else begin : g_pipe
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [WIDTH-1:0] stage_reg;
        logic [WIDTH-1:0] stage_next;

        if (gi == 0) begin : g_head
          assign stage_next = din;
        end else begin : g_tail
          assign stage_next = g_stage[gi-1].stage_reg;
        end

        // One delay stage; cleared to the inactive (high) sync level
        always_ff @(posedge vga_clk or negedge reset_n) begin
          if (!reset_n) begin
            stage_reg <= '1;
          end else begin
            stage_reg <= stage_next;
          end
        end
      end

      assign dout = g_stage[DEPTH-1].stage_reg;
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters for the display path. DrawX/DrawY come
// straight from the counter registers; blank and frame_start are decoded from
// them with no added latency, while hs/vs go through a short delay line so
// they line up with the renderers' registered colour outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = H_VISIBLE_640,
  parameter int unsigned H_FRONT    = H_FRONT_640,
  parameter int unsigned H_SYNC     = H_SYNC_640,
  parameter int unsigned H_BACK     = H_BACK_640,
  parameter int unsigned V_VISIBLE  = V_VISIBLE_640,
  parameter int unsigned V_FRONT    = V_FRONT_640,
  parameter int unsigned V_SYNC     = V_SYNC_640,
  parameter int unsigned V_BACK     = V_BACK_640,
  parameter int unsigned SYNC_DELAY = 1
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  output coord_t      DrawX,
  output coord_t      DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int unsigned H_TOTAL = span_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = span_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  // Reject timings the 10-bit counters cannot represent
  generate
    if (H_TOTAL > MAX_TOTAL) begin : g_bad_h_total
      $error("vga_timing_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > MAX_TOTAL) begin : g_bad_v_total
      $error("vga_timing_gen: V_TOTAL exceeds 1024");
    end
    if (SYNC_DELAY > MAX_SYNC_DELAY) begin : g_bad_sync_delay
      $error("vga_timing_gen: SYNC_DELAY must be 0..4");
    end
  endgenerate

  // Decode windows are compared one bit wider than the counters so a window
  // ending exactly at 1024 does not alias to zero.
  localparam int unsigned EXT_W = COORD_W + 1;
  localparam logic [EXT_W-1:0] H_VIS_X    = EXT_W'(H_VISIBLE);
  localparam logic [EXT_W-1:0] V_VIS_X    = EXT_W'(V_VISIBLE);
  localparam logic [EXT_W-1:0] HS_START_X = EXT_W'(H_VISIBLE + H_FRONT);
  localparam logic [EXT_W-1:0] HS_STOP_X  = EXT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [EXT_W-1:0] VS_START_X = EXT_W'(V_VISIBLE + V_FRONT);
  localparam logic [EXT_W-1:0] VS_STOP_X  = EXT_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

  coord_t      hc_reg, hc_next;
  coord_t      vc_reg, vc_next;
  logic [15:0] frame_count_reg, frame_count_next;
  logic        line_end, frame_end;

  logic [EXT_W-1:0] hc_ext, vc_ext;
  logic             hs_raw, vs_raw;
  logic [1:0]       sync_out;

  // Next-state for the raster counters; line and frame wrap share one edge
  always_comb begin
    hc_next          = hc_reg + coord_t'(1);
    vc_next          = vc_reg;
    frame_count_next = frame_count_reg;
    line_end         = (hc_reg == H_LAST);
    frame_end        = line_end && (vc_reg == V_LAST);
    if (line_end) begin
      hc_next = '0;
      vc_next = frame_end ? coord_t'(0) : vc_reg + coord_t'(1);
    end
    if (frame_end) begin
      frame_count_next = frame_count_reg + 16'd1;
    end
  end

  // Counter registers; reset parks on the last pixel so the first edge
  // after release lands on (0,0) and counts as a completed frame
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_reg          <= H_LAST;
      vc_reg          <= V_LAST;
      frame_count_reg <= '0;
    end else begin
      hc_reg          <= hc_next;
      vc_reg          <= vc_next;
      frame_count_reg <= frame_count_next;
    end
  end

  assign hc_ext = {1'b0, hc_reg};
  assign vc_ext = {1'b0, vc_reg};

  // Undelayed decodes, consumed alongside DrawX/DrawY
  assign blank       = (hc_ext < H_VIS_X) && (vc_ext < V_VIS_X);
  assign frame_start = (hc_reg == '0) && (vc_reg == '0);

  // Active-low sync windows before alignment
  assign hs_raw = !((hc_ext >= HS_START_X) && (hc_ext < HS_STOP_X));
  assign vs_raw = !((vc_ext >= VS_START_X) && (vc_ext < VS_STOP_X));

  sync_delay #(
    .DEPTH (SYNC_DELAY),
    .WIDTH (2)
  ) u_sync_delay (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .din     ({hs_raw, vs_raw}),
    .dout    (sync_out)
  );

  assign hs          = sync_out[1];
  assign vs          = sync_out[0];
  assign DrawX       = hc_reg;
  assign DrawY       = vc_reg;
  assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three default-timing generators (SYNC_DELAY 0, 1, 4)
// run in lockstep against a cycle model through a scoreboard queue, plus a
// tiny-timing generator used for whole-frame, wrap and mid-frame reset checks.
`timescale 1ns/1ps
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;
  always #20 vga_clk = ~vga_clk;

  coord_t      d1_x, d1_y, d0_x, d0_y, d4_x, d4_y, ds_x, ds_y;
  logic        d1_blank, d1_hs, d1_vs, d1_fs;
  logic        d0_blank, d0_hs, d0_vs, d0_fs;
  logic        d4_blank, d4_hs, d4_vs, d4_fs;
  logic        ds_blank, ds_hs, ds_vs, ds_fs;
  logic [15:0] d1_fc, d0_fc, d4_fc, ds_fc;

  vga_timing_gen #(.SYNC_DELAY(1)) u_d1 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(d1_x), .DrawY(d1_y),
    .blank(d1_blank), .hs(d1_hs), .vs(d1_vs), .frame_start(d1_fs), .frame_count(d1_fc));

  vga_timing_gen #(.SYNC_DELAY(0)) u_d0 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(d0_x), .DrawY(d0_y),
    .blank(d0_blank), .hs(d0_hs), .vs(d0_vs), .frame_start(d0_fs), .frame_count(d0_fc));

  vga_timing_gen #(.SYNC_DELAY(4)) u_d4 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(d4_x), .DrawY(d4_y),
    .blank(d4_blank), .hs(d4_hs), .vs(d4_vs), .frame_start(d4_fs), .frame_count(d4_fc));

  // Tiny raster: 24 x 12 = 288 cycles per frame, hs raw low x=18..21, vs raw low y=8..9
  vga_timing_gen #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_VISIBLE(6),  .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .SYNC_DELAY(2)
  ) u_ds (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(ds_x), .DrawY(ds_y),
    .blank(ds_blank), .hs(ds_hs), .vs(ds_vs), .frame_start(ds_fs), .frame_count(ds_fc));

  int total_cnt = 0;
  int bad_cnt   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model for the 640x480 instances -------------
  int   m_x, m_y, m_fc;
  logic raw_hs [0:4];
  logic raw_vs [0:4];

  typedef struct packed {
    logic [39:0] e1;
    logic [39:0] e0;
    logic [39:0] e4;
  } exp_t;

  exp_t sb_q[$];

  task automatic model_reset();
    m_x  = 799;
    m_y  = 524;
    m_fc = 0;
    for (int k = 0; k < 5; k++) begin
      raw_hs[k] = 1'b1;
      raw_vs[k] = 1'b1;
    end
  endtask

  task automatic model_step();
    for (int k = 4; k > 0; k--) begin
      raw_hs[k] = raw_hs[k-1];
      raw_vs[k] = raw_vs[k-1];
    end
    if (m_x == 799) begin
      m_x = 0;
      if (m_y == 524) begin
        m_y  = 0;
        m_fc = (m_fc + 1) % 65536;
      end else begin
        m_y++;
      end
    end else begin
      m_x++;
    end
    raw_hs[0] = !(m_x >= 656 && m_x < 752);
    raw_vs[0] = !(m_y >= 490 && m_y < 492);
  endtask

  function automatic logic [39:0] exp_of(input int d);
    logic b, f;
    b = (m_x < 640) && (m_y < 480);
    f = (m_x == 0) && (m_y == 0);
    return {10'(m_x), 10'(m_y), b, f, raw_hs[d], raw_vs[d], 16'(m_fc)};
  endfunction

  function automatic exp_t model_exp();
    exp_t e;
    e.e1 = exp_of(1);
    e.e0 = exp_of(0);
    e.e4 = exp_of(4);
    return e;
  endfunction

  task automatic sb_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq("cyc_d1", {d1_x, d1_y, d1_blank, d1_fs, d1_hs, d1_vs, d1_fc}, e.e1);
      check_eq("cyc_d0", {d0_x, d0_y, d0_blank, d0_fs, d0_hs, d0_vs, d0_fc}, e.e0);
      check_eq("cyc_d4", {d4_x, d4_y, d4_blank, d4_fs, d4_hs, d4_vs, d4_fc}, e.e4);
    end
  endtask

  // One clock: model advances with the DUT edge, comparison on the falling edge
  task automatic tick();
    @(posedge vga_clk);
    if (reset_n) model_step();
    sb_q.push_back(model_exp());
    @(negedge vga_clk);
    sb_check();
  endtask

  task automatic wait_ds_fs(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      if (ds_fs) seen = 1'b1;
    end
    check_eq(tag, 64'(seen), 64'd1);
  endtask

  initial begin
    int blank_fall, hs1_fall, hs0_fall, hs4_fall, hs1_low;
    int fs_cnt, fs_first, vs_low, vs_fall_x, vs_fall_y;
    logic p_blank, p_hs1, p_hs0, p_hs4, p_vs;
    logic [15:0] fc0;
    bit both_low;

    // ---- reset held 10 cycles ----
    reset_n = 1'b0;
    model_reset();
    repeat (10) tick();
    check_eq("rst_x", 64'(d1_x), 64'd799);
    check_eq("rst_y", 64'(d1_y), 64'd524);
    check_eq("rst_blank_hs_vs", {d1_blank, d1_hs, d1_vs, d1_fs}, 4'b0110);

    // ---- first edge after release ----
    reset_n = 1'b1;
    tick();
    check_eq("rel_xy", {d1_x, d1_y}, 20'd0);
    check_eq("rel_blank_fs", {d1_blank, d1_fs}, 2'b11);
    check_eq("rel_fc", 64'(d1_fc), 64'd1);

    // ---- one line from (0,0) ----
    blank_fall = -1; hs1_fall = -1; hs0_fall = -1; hs4_fall = -1; hs1_low = 0;
    p_blank = d1_blank; p_hs1 = d1_hs; p_hs0 = d0_hs; p_hs4 = d4_hs;
    for (int i = 1; i <= 800; i++) begin
      tick();
      if (p_blank && !d1_blank && blank_fall < 0) blank_fall = int'(d1_x);
      if (p_hs1 && !d1_hs && hs1_fall < 0) hs1_fall = int'(d1_x);
      if (p_hs0 && !d0_hs && hs0_fall < 0) hs0_fall = int'(d0_x);
      if (p_hs4 && !d4_hs && hs4_fall < 0) hs4_fall = int'(d4_x);
      if (!d1_hs) hs1_low++;
      p_blank = d1_blank; p_hs1 = d1_hs; p_hs0 = d0_hs; p_hs4 = d4_hs;
    end
    check_eq("blank_fall_x", 64'(blank_fall), 64'd640);
    check_eq("hs1_fall_x", 64'(hs1_fall), 64'd657);
    check_eq("hs1_low_len", 64'(hs1_low), 64'd96);
    check_eq("hs0_fall_x", 64'(hs0_fall), 64'd656);
    check_eq("hs4_fall_x", 64'(hs4_fall), 64'd660);
    check_eq("line_wrap_xy", {d1_x, d1_y}, {10'd0, 10'd1});

    // ---- whole frames on the tiny raster ----
    wait_ds_fs("ds_fs_wait1");
    check_eq("ds_origin", {ds_x, ds_y}, 20'd0);
    fs_cnt = 0; fs_first = -1; vs_low = 0; vs_fall_x = -1; vs_fall_y = -1;
    fc0 = ds_fc;
    p_vs = ds_vs;
    for (int i = 1; i <= 576; i++) begin
      tick();
      if (ds_fs) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = i;
      end
      if (!ds_vs && i <= 288) vs_low++;
      if (p_vs && !ds_vs && vs_fall_x < 0) begin
        vs_fall_x = int'(ds_x);
        vs_fall_y = int'(ds_y);
      end
      p_vs = ds_vs;
    end
    check_eq("ds_frame_period", 64'(fs_first), 64'd288);
    check_eq("ds_fs_count", 64'(fs_cnt), 64'd2);
    check_eq("ds_fc_delta", 64'(ds_fc - fc0), 64'd2);
    check_eq("ds_vs_low_len", 64'(vs_low), 64'd48);
    check_eq("ds_vs_fall_xy", {vs_fall_y, vs_fall_x}, {32'd8, 32'd2});

    // ---- frame_count wrap from 0xFFFF ----
    force u_ds.frame_count_reg = 16'hFFFF;
    tick();
    release u_ds.frame_count_reg;
    tick();
    check_eq("fc_preload", 64'(ds_fc), 64'hFFFF);
    wait_ds_fs("ds_fs_wait2");
    check_eq("fc_wrap", 64'(ds_fc), 64'h0000);

    // ---- mid-frame reset while hs and vs are both low ----
    both_low = 1'b0;
    for (int i = 0; i < 400 && !both_low; i++) begin
      tick();
      if (!ds_hs && !ds_vs) both_low = 1'b1;
    end
    check_eq("ds_sync_low_wait", 64'(both_low), 64'd1);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_eq("mid_rst_ds", {ds_x, ds_y, ds_blank, ds_fs, ds_hs, ds_vs, ds_fc},
             {10'd23, 10'd11, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0});
    check_eq("mid_rst_d1", {d1_x, d1_y, d1_blank, d1_fs, d1_hs, d1_vs, d1_fc},
             {10'd799, 10'd524, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0});
    check_eq("mid_rst_d4_sync", {d4_hs, d4_vs}, 2'b11);
    sb_q.push_back(model_exp());
    sb_check();
    repeat (5) tick();
    reset_n = 1'b1;
    repeat (30) tick();
    check_eq("resume_x", 64'(d1_x), 64'd29);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
